// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle pacing FSM that sits between instruction decode and the
//   datapath. It paces each instruction ID over several cycles, inserts
//   memory wait states, handshakes I/O transfers, and handles HALT/resume
//   and soft reset. `commit` is the single-cycle gate for register-bank/PC
//   write-back.
//
// Ports
//   clock, reset (async, active-low)
//   instr_id/instr_valid : decoded instruction offered in FETCH
//   stall                : freeze (state, ID and counters hold; strobes off)
//   io_ack, resume       : peripheral completion / leave HALTED
//   ready, busy          : accepting an ID / instruction in flight
//   commit               : one-cycle write-back / PC-advance pulse
//   mem_read_active      : level, load in progress
//   mem_write_strobe     : one-cycle store strobe
//   io_request           : level, I/O handshake pending
//   io_timeout           : one-cycle pulse when an I/O wait is abandoned
//   halted, soft_reset   : halted level / one-cycle datapath reset pulse
//   current_id, state    : latched ID and FSM state code
module control_sequencer #(
  parameter int ID_WIDTH   = 7,
  parameter int MEM_WAIT   = 2,
  parameter int HALT_ID    = 75,
  parameter int RESET_ID   = 100,
  parameter int IO_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_WIDTH-1:0] instr_id,
  input  logic                instr_valid,
  input  logic                stall,
  input  logic                io_ack,
  input  logic                resume,
  output logic                ready,
  output logic                busy,
  output logic                commit,
  output logic                mem_read_active,
  output logic                mem_write_strobe,
  output logic                io_request,
  output logic                io_timeout,
  output logic                halted,
  output logic                soft_reset,
  output logic [ID_WIDTH-1:0] current_id,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_MEM     = 3'd2,
    S_COMMIT  = 3'd3,
    S_IO_WAIT = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_IO, CLS_HALT, CLS_SRST
  } id_class_t;

  // wait_cnt is loaded with MEM_WAIT-1 so MEM lasts exactly MEM_WAIT cycles.
  localparam logic [3:0] WAIT_INIT     = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;
  // io_cnt counts completed IO_WAIT cycles; the abort happens in the
  // IO_TIMEOUT-th IO_WAIT cycle, i.e. when io_cnt holds IO_TIMEOUT-1.
  localparam logic [7:0] IO_LAST       = (IO_TIMEOUT > 0) ? 8'(IO_TIMEOUT - 1) : 8'd0;
  localparam bit         MEM_WAIT_ZERO = (MEM_WAIT == 0);
  localparam bit         TIMEOUT_EN    = (IO_TIMEOUT != 0);

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] current_id_q, current_id_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [7:0]          io_cnt_q, io_cnt_d;
  id_class_t           id_class;
  logic                is_load, is_store;

  // HALT/SRST are tested first so a parameter collision with a memory ID
  // still yields a defined class. Anything unlisted is an ALU-class pass.
  function automatic id_class_t classify(input logic [ID_WIDTH-1:0] id);
    int v;
    v = int'(id);
    if (v == HALT_ID)                                      return CLS_HALT;
    if (v == RESET_ID)                                     return CLS_SRST;
    if (v inside {40, 41, 42, 48, 50, 52, 54, 67})         return CLS_STORE;
    if (v inside {39, 43, 44, 45, 46, 47, 49, 51, 53, 55, 68}) return CLS_LOAD;
    if (v inside {69, 70, 71})                             return CLS_IO;
    return CLS_ALU;
  endfunction

  assign id_class   = classify(current_id_q);
  assign is_load    = (id_class == CLS_LOAD);
  assign is_store   = (id_class == CLS_STORE);
  assign current_id = current_id_q;
  assign state      = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      current_id_q <= '0;
      wait_cnt_q   <= '0;
      io_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      current_id_q <= current_id_d;
      wait_cnt_q   <= wait_cnt_d;
      io_cnt_q     <= io_cnt_d;
    end
  end

  // All outputs decode from the registered state, so an asynchronous reset
  // drops every strobe in the same instant it lands. Pulses are qualified
  // by !stall; levels (mem_read_active, io_request) are not.
  always_comb begin
    state_d          = state_q;
    current_id_d     = current_id_q;
    wait_cnt_d       = wait_cnt_q;
    io_cnt_d         = io_cnt_q;
    ready            = 1'b0;
    busy             = 1'b0;
    commit           = 1'b0;
    mem_read_active  = 1'b0;
    mem_write_strobe = 1'b0;
    io_request       = 1'b0;
    io_timeout       = 1'b0;
    halted           = 1'b0;
    soft_reset       = 1'b0;

    case (state_q)
      S_FETCH: begin
        ready = 1'b1;
        if (instr_valid && !stall) begin
          current_id_d = instr_id;
          state_d      = S_EXEC;
        end
      end

      S_EXEC: begin
        busy = 1'b1;
        if (!stall) begin
          case (id_class)
            CLS_LOAD, CLS_STORE: begin
              if (MEM_WAIT_ZERO) begin
                mem_write_strobe = is_store;
                state_d          = S_COMMIT;
              end else begin
                wait_cnt_d = WAIT_INIT;
                state_d    = S_MEM;
              end
            end
            CLS_IO: begin
              io_cnt_d = 8'd0;
              state_d  = S_IO_WAIT;
            end
            CLS_HALT: state_d = S_HALTED;
            CLS_SRST: begin
              soft_reset = 1'b1;
              state_d    = S_FETCH;
            end
            default:  state_d = S_COMMIT;
          endcase
        end
      end

      S_MEM: begin
        busy            = 1'b1;
        mem_read_active = is_load;
        if (!stall) begin
          if (wait_cnt_q == 4'd0) begin
            mem_write_strobe = is_store;
            state_d          = S_COMMIT;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
      end

      S_COMMIT: begin
        busy = 1'b1;
        if (!stall) begin
          commit  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_IO_WAIT: begin
        busy       = 1'b1;
        io_request = 1'b1;
        if (!stall) begin
          // io_ack takes priority over a timeout landing in the same cycle.
          if (io_ack) begin
            state_d = S_COMMIT;
          end else if (TIMEOUT_EN && (io_cnt_q >= IO_LAST)) begin
            io_timeout = 1'b1;
            state_d    = S_FETCH;
          end else if (io_cnt_q != 8'hFF) begin
            io_cnt_d = io_cnt_q + 8'd1;
          end
        end
      end

      S_HALTED: begin
        // stall is irrelevant here: resume always wins, instr_valid ignored.
        halted = 1'b1;
        if (resume) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Two sequencer instances share one stimulus stream: instance 0 uses
//   MEM_WAIT=2 / IO_TIMEOUT=12, instance 1 uses MEM_WAIT=0 / IO_TIMEOUT=5.
//   A per-instance behavioural model (instruction class + count of
//   elapsed non-stalled cycles) predicts every output each cycle; a set of
//   literal expectations from hand-worked timelines pins the model.
module tb_control_sequencer;

  localparam int NDUT = 2;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_IO = 3, K_HALT = 4, K_SRST = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      instr_id;
  logic            instr_valid, stall, io_ack, resume;
  logic [NDUT-1:0] ready_o, busy_o, commit_o, rd_o, wr_o, req_o, tmo_o, halt_o, srst_o;
  logic [6:0]      cur_o [NDUT];
  logic [2:0]      st_o  [NDUT];

  int checks = 0;
  int errors = 0;

  // Model state per instance.
  bit         m_act    [NDUT];
  bit         m_halt   [NDUT];
  bit         m_iodone [NDUT];
  int         m_kind   [NDUT];
  int         m_el     [NDUT];
  logic [6:0] m_cur    [NDUT];

  int ids [16] = '{4, 0, 127, 39, 40, 44, 48, 67, 68, 69, 70, 71, 75, 100, 12, 55};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      control_sequencer #(
        .ID_WIDTH  (7),
        .MEM_WAIT  ((gi == 0) ? 2 : 0),
        .HALT_ID   (75),
        .RESET_ID  (100),
        .IO_TIMEOUT((gi == 0) ? 12 : 5)
      ) u_dut (
        .clock           (clk),
        .reset           (rst_n),
        .instr_id        (instr_id),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .io_ack          (io_ack),
        .resume          (resume),
        .ready           (ready_o[gi]),
        .busy            (busy_o[gi]),
        .commit          (commit_o[gi]),
        .mem_read_active (rd_o[gi]),
        .mem_write_strobe(wr_o[gi]),
        .io_request      (req_o[gi]),
        .io_timeout      (tmo_o[gi]),
        .halted          (halt_o[gi]),
        .soft_reset      (srst_o[gi]),
        .current_id      (cur_o[gi]),
        .state           (st_o[gi])
      );
    end
  endgenerate

  function automatic int mw_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int to_of(input int i);
    return (i == 0) ? 12 : 5;
  endfunction

  function automatic int kind_of(input logic [6:0] id);
    int v;
    v = int'(id);
    if (v == 75)  return K_HALT;
    if (v == 100) return K_SRST;
    if (v inside {40, 41, 42, 48, 50, 52, 54, 67}) return K_STORE;
    if (v inside {39, 43, 44, 45, 46, 47, 49, 51, 53, 55, 68}) return K_LOAD;
    if (v inside {69, 70, 71}) return K_IO;
    return K_ALU;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Compare process: predicts this cycle's outputs from the model and the
  // current inputs, compares, then advances the model as the coming rising
  // edge will (inputs are stable until then).
  task automatic model_cycle();
    for (int i = 0; i < NDUT; i++) begin
      int es, el, k, mw, lim;
      bit e_rdy, e_busy, e_com, e_rd, e_wr, e_req, e_tmo, e_halt, e_srst, tmo_now;
      es = 0; e_rdy = 0; e_busy = 0; e_com = 0; e_rd = 0; e_wr = 0;
      e_req = 0; e_tmo = 0; e_halt = 0; e_srst = 0; tmo_now = 0;
      el = m_el[i]; k = m_kind[i]; mw = mw_of(i); lim = to_of(i);

      if (!rst_n) begin
        m_act[i] = 0; m_halt[i] = 0; m_cur[i] = '0;
        e_rdy = 1;
      end else if (m_halt[i]) begin
        es = 5; e_halt = 1;
      end else if (!m_act[i]) begin
        es = 0; e_rdy = 1;
      end else begin
        e_busy = 1;
        if (el == 0) begin
          es     = 1;
          e_srst = (k == K_SRST) && !stall;
          e_wr   = (k == K_STORE) && (mw == 0) && !stall;
        end else if (k == K_IO && !m_iodone[i]) begin
          // el is the 1-based number of this IO_WAIT cycle
          es      = 4;
          e_req   = 1;
          tmo_now = (lim != 0) && (el >= lim) && !io_ack;
          e_tmo   = tmo_now && !stall;
        end else if ((k == K_LOAD || k == K_STORE) && el <= mw) begin
          es   = 2;
          e_rd = (k == K_LOAD);
          e_wr = (k == K_STORE) && (el == mw) && !stall;
        end else begin
          es    = 3;
          e_com = !stall;
        end
      end

      check("state",      i, 32'(st_o[i]),     es);
      check("ready",      i, 32'(ready_o[i]),  32'(e_rdy));
      check("busy",       i, 32'(busy_o[i]),   32'(e_busy));
      check("commit",     i, 32'(commit_o[i]), 32'(e_com));
      check("mem_read",   i, 32'(rd_o[i]),     32'(e_rd));
      check("mem_write",  i, 32'(wr_o[i]),     32'(e_wr));
      check("io_request", i, 32'(req_o[i]),    32'(e_req));
      check("io_timeout", i, 32'(tmo_o[i]),    32'(e_tmo));
      check("halted",     i, 32'(halt_o[i]),   32'(e_halt));
      check("soft_reset", i, 32'(srst_o[i]),   32'(e_srst));
      check("current_id", i, 32'(cur_o[i]),    32'(m_cur[i]));

      if (rst_n) begin
        if (m_halt[i]) begin
          if (resume) m_halt[i] = 0;
        end else if (!m_act[i]) begin
          if (instr_valid && !stall) begin
            m_act[i] = 1; m_el[i] = 0; m_iodone[i] = 0;
            m_kind[i] = kind_of(instr_id); m_cur[i] = instr_id;
          end
        end else if (!stall) begin
          if (es == 1) begin
            if (k == K_HALT) begin
              m_act[i] = 0; m_halt[i] = 1;
            end else if (k == K_SRST) begin
              m_act[i] = 0;
            end else begin
              m_el[i] = 1;
            end
          end else if (es == 3) begin
            m_act[i] = 0;
          end else if (es == 4) begin
            if (io_ack)       m_iodone[i] = 1;
            else if (tmo_now) m_act[i] = 0;
            else              m_el[i] = el + 1;
          end else begin
            m_el[i] = el + 1;
          end
        end
      end
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // checked on the falling edge.
  task automatic step(input bit r, input bit v, input int id, input bit st,
                      input bit ack, input bit res);
    @(posedge clk);
    #1;
    rst_n = r; instr_valid = v; instr_id = 7'(id); stall = st; io_ack = ack; resume = res;
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_id = '0;
    stall = 1'b0; io_ack = 1'b0; resume = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      check("rst_ready", i, 32'(ready_o[i]), 32'd1);
      check("rst_state", i, 32'(st_o[i]),    32'd0);
      check("rst_busy",  i, 32'(busy_o[i]),  32'd0);
      check("rst_cur",   i, 32'(cur_o[i]),   32'd0);
    end
    $display("txn reset");

    // ALU ID 4: EXEC at T1, commit at T2 only, ready at T3
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) check("alu_t0_ready", i, 32'(ready_o[i]), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      check("alu_t1_state",  i, 32'(st_o[i]),     32'd1);
      check("alu_t1_commit", i, 32'(commit_o[i]), 32'd0);
      check("alu_t1_cur",    i, 32'(cur_o[i]),    32'd4);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) check("alu_t2_commit", i, 32'(commit_o[i]), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      check("alu_t3_ready",  i, 32'(ready_o[i]),  32'd1);
      check("alu_t3_commit", i, 32'(commit_o[i]), 32'd0);
    end
    $display("txn alu id=4");

    // STORE ID 40: dut0 strobes in 2nd MEM cycle (T3), commits T4;
    // dut1 strobes in EXEC (T1), commits T2.
    step(1, 1, 40, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("st_t1_wr_mw0", 1, 32'(wr_o[1]), 32'd1);
    check("st_t1_wr_mw2", 0, 32'(wr_o[0]), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("st_t2_state", 0, 32'(st_o[0]),     32'd2);
    check("st_t2_wr",    0, 32'(wr_o[0]),     32'd0);
    check("st_t2_commit",1, 32'(commit_o[1]), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("st_t3_wr",    0, 32'(wr_o[0]),     32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("st_t4_commit",0, 32'(commit_o[0]), 32'd1);
    check("st_t4_wr",    0, 32'(wr_o[0]),     32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("st_t5_ready", 0, 32'(ready_o[0]),  32'd1);
    $display("txn store id=40");

    // LOAD ID 44 with a 3-cycle stall in MEM: commit moves from T4 to T7
    step(1, 1, 44, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    check("ld_stall_rd",     0, 32'(rd_o[0]),     32'd1);
    check("ld_stall_state",  0, 32'(st_o[0]),     32'd2);
    check("ld_stall_commit", 1, 32'(commit_o[1]), 32'd0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("ld_t5_commit", 0, 32'(commit_o[0]), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("ld_t6_commit", 0, 32'(commit_o[0]), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("ld_t7_commit", 0, 32'(commit_o[0]), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    $display("txn load id=44 stall=3");

    // HALT, ignored instruction, resume (with stall) wins
    step(1, 1, 75, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      check("halt_halted", i, 32'(halt_o[i]),  32'd1);
      check("halt_ready",  i, 32'(ready_o[i]), 32'd0);
      check("halt_state",  i, 32'(st_o[i]),    32'd5);
    end
    step(1, 1, 4, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < NDUT; i++) check("halt_cur", i, 32'(cur_o[i]), 32'd75);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) check("resume_ready", i, 32'(ready_o[i]), 32'd1);
    $display("txn halt id=75 resume");

    // Soft reset: one pulse in EXEC, no commit
    step(1, 1, 100, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      check("srst_pulse",  i, 32'(srst_o[i]),   32'd1);
      check("srst_commit", i, 32'(commit_o[i]), 32'd0);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NDUT; i++) check("srst_done", i, 32'(srst_o[i]), 32'd0);
    $display("txn soft_reset id=100");

    // Asynchronous reset landing in the strobe cycle of ID 40 on dut0
    step(1, 1, 40, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr",    0, 32'(wr_o[0]),    32'd0);
    check("arst_state", 0, 32'(st_o[0]),    32'd0);
    check("arst_ready", 0, 32'(ready_o[0]), 32'd1);
    check("arst_busy",  0, 32'(busy_o[0]),  32'd0);
    step(0, 0, 0, 0, 0, 0);
    $display("txn async reset during store");

    // I/O ID 71: ack on the 10th IO_WAIT cycle for dut0; dut1 times out at 5
    step(1, 1, 71, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int kk = 1; kk <= 10; kk++) begin
      step(1, 0, 0, 0, kk == 10, 0);
      check("io_request", 0, 32'(req_o[0]), 32'd1);
      check("io_tmo_at5", 1, 32'(tmo_o[1]), 32'(kk == 5));
    end
    step(1, 0, 0, 0, 0, 0);
    check("io_commit",    0, 32'(commit_o[0]), 32'd1);
    check("io_tmo_nocmt", 1, 32'(commit_o[1]), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    $display("txn io id=71");

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)),
           ids[$urandom_range(0, 15)], $urandom_range(0, 4) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0);
    end
    $display("txn random 3000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control sequencer that sits beside the combinational control core, between instruction decode and the datapath. It takes the 7-bit instruction ID and paces execution over several cycles. It inserts parametrised memory wait states, handshakes I/O instructions (OUTSS/OUTLED/INSW) with the peripheral side, and implements HALT/resume and soft RESET. Its commit pulse gates the register-bank/PC `enable` the control core produces.

Parameters:
ID_WIDTH, 7, width of instruction ID bus
MEM_WAIT, 2, extra cycles held for every load/store (0..15)
HALT_ID, 75, ID that enters HALTED
RESET_ID, 100, ID that triggers soft reset
IO_TIMEOUT, 255, max IO_WAIT cycles before abort (0 = wait forever)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_id  in  ID_WIDTH  decoded instruction ID
instr_valid  in  1  instr_id valid this cycle
stall  in  1  freeze sequencer (external hazard)
io_ack  in  1  peripheral completed I/O transfer
resume  in  1  leave HALTED
ready  out  1  sequencer accepts instr_id this cycle
busy  out  1  instruction in flight
commit  out  1  one-cycle write-back/PC-advance pulse
mem_read_active  out  1  load in progress
mem_write_strobe  out  1  one-cycle store strobe
io_request  out  1  I/O handshake request
io_timeout  out  1  one-cycle pulse on I/O abort
halted  out  1  sequencer halted
soft_reset  out  1  one-cycle datapath reset pulse
current_id  out  ID_WIDTH  latched instruction ID
state  out  3  FSM state code

Behaviour:
- Reset (reset=0, async):
  - state=FETCH, current_id=0, counters=0.
  - ready=1. busy, commit, mem_read_active, mem_write_strobe, io_request, io_timeout, halted and soft_reset are all 0.
- ID classes:
  - STORE = {40,41,42,48,50,52,54,67}.
  - LOAD = {39,43,44,45,46,47,49,51,53,55,68}.
  - IO = {69,70,71}.
  - HALT = HALT_ID. SRST = RESET_ID. Everything else is ALU.
- States and codes: FETCH=0, EXEC=1, MEM=2, COMMIT=3, IO_WAIT=4, HALTED=5.
- FETCH:
  - ready=1, busy=0.
  - If instr_valid=1 and stall=0: latch current_id=instr_id and go to EXEC.
- EXEC (one cycle, busy=1):
  - ALU -> COMMIT.
  - LOAD/STORE, MEM_WAIT>0 -> MEM with wait_cnt=MEM_WAIT-1.
  - LOAD/STORE, MEM_WAIT=0 -> COMMIT. mem_write_strobe=1 in EXEC if STORE.
  - IO -> IO_WAIT with io_cnt=0.
  - HALT -> HALTED.
  - SRST -> soft_reset=1 this cycle, then FETCH with no commit.
- MEM:
  - mem_read_active=1 for LOAD throughout.
  - Decrement wait_cnt each cycle. At wait_cnt=0, STORE asserts mem_write_strobe for exactly that cycle, then go to COMMIT.
- IO_WAIT:
  - io_request=1 until io_ack=1 sampled, then COMMIT.
  - io_ack arriving in the same cycle IO_WAIT is entered is honoured.
  - If IO_TIMEOUT!=0 and io_cnt reaches IO_TIMEOUT: pulse io_timeout, go to FETCH without commit.
- COMMIT: commit=1 for one cycle, then FETCH.
- HALTED:
  - halted=1, busy=0, ready=0.
  - resume=1 -> FETCH next cycle.
  - instr_valid is ignored.
- Latency:
  - ALU: instr_valid sampled at T0, commit at T2, ready again at T3.
  - LOAD/STORE: commit at T2+MEM_WAIT.
- Stall:
  - When stall=1 in any state except HALTED: state, current_id and counters hold.
  - commit, mem_write_strobe, soft_reset and io_timeout are forced to 0.
  - mem_read_active and io_request hold their level.
  - Strobes fire on the first non-stalled cycle.
- Simultaneous events:
  - resume and stall together in HALTED: resume wins.
  - io_ack and a timeout in the same cycle: io_ack wins.
- Unknown/out-of-range IDs (e.g. 0, 127) are treated as ALU class, i.e. a NOP-like 3-cycle pass.
- Async reset mid-operation aborts immediately. No strobe may be emitted in the reset cycle.
- Counters are 4-bit (wait_cnt) and 8-bit (io_cnt) and never wrap: they saturate at their terminal value.

Test Plan:
- Reset then ID=4 valid at T0 -> state 1 at T1, commit=1 at T2 only, ready=1 at T3, current_id=4.
- MEM_WAIT=2, ID=40 -> state 2 for 2 cycles, mem_write_strobe=1 exactly once (second MEM cycle), commit next cycle, total 5 cycles to ready. With MEM_WAIT=0, strobe occurs in EXEC.
- ID=44 with stall=1 for 3 cycles mid-MEM -> mem_read_active stays 1, commit delayed by exactly 3 cycles, one commit pulse total.
- ID=71, io_ack after 10 cycles -> io_request=1 for 10 cycles, then commit. IO_TIMEOUT=5 with no ack -> io_timeout pulse at cycle 5 of IO_WAIT, no commit, back to FETCH.
- ID=75 -> halted=1, ready=0. Further ID=4 valid is ignored. resume -> FETCH, ready=1. ID=100 -> single soft_reset pulse, no commit.
- Assert reset low during MEM of ID=40 -> all outputs 0 (ready=1) asynchronously, no write strobe, state=0.
